// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch front end.
//   XLEN             : data/address width
//   END_MARKER       : instruction word that terminates the program
//   DEFAULT_RESET_PC : default address of the first fetch after reset
//   FETCH_DEPTH      : number of fetched words the decode-side buffer holds
//   fetch_entry_t    : one buffered fetch result {instr, pc}
package instruction_fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] END_MARKER = '0;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = '0;
  localparam int unsigned FETCH_DEPTH = 2;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of fetch entries sitting between instruction memory and decode.
//   clk, reset : clock, asynchronous active-high reset
//   i_push     : write i_data at the tail
//   i_pop      : drop the head entry (ignored when empty)
//   i_flush    : discard all entries; wins over push/pop
//   i_data     : entry to push
//   o_count    : number of valid entries
//   o_head     : oldest entry (stale contents when o_count == 0)
// Push and pop may occur in the same cycle; the producer must never push
// into a full buffer unless it also pops.
module fetch_buffer
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_DEPTH,
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_data,
  output logic [CW-1:0] o_count,
  output fetch_entry_t o_head
);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_do_push = i_push & ~i_flush;
  assign w_do_pop  = i_pop & ~i_flush & (r_count != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch front end: owns the PC, issues one-word reads to the
// instruction memory (1-cycle read latency) and hands fetched words to
// decode through a 2-entry buffer. An all-zero word halts fetching; a
// redirect reloads the PC and flushes buffered and in-flight work.
//   clk, reset      : clock, asynchronous active-high reset
//   stall           : decode not accepting; head word held
//   redirect_valid  : reload PC from redirect_pc, flush
//   redirect_pc     : new PC (low two bits ignored)
//   imem_req/addr   : read request and word-aligned byte address
//   imem_rdata      : read data, one cycle after the request
//   is_input_valid  : instruction/pc_out hold a valid word
//   instruction     : fetched word at buffer head
//   pc_out          : address of instruction
//   halted          : end-of-program marker seen, fetching stopped
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            is_input_valid,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] pc_out,
  output logic            halted
);

  localparam int unsigned CW = $clog2(FETCH_DEPTH + 1);

  logic [XLEN-1:0] r_pc;
  logic            r_inflight;
  logic [XLEN-1:0] r_inflight_addr;
  logic            r_kill;
  logic            r_halted;

  logic [CW-1:0]   w_count;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_data;
  logic            w_pop;
  logic            w_req;
  logic            w_resp_ok;
  logic            w_push;
  logic            w_end;
  logic [CW:0]     w_occupancy;

  assign w_pop = is_input_valid & ~stall & ~redirect_valid;

  // Credit check written as occupancy < DEPTH + pop so the unsigned
  // arithmetic never has to go below zero.
  assign w_occupancy = (CW + 1)'(w_count) + (CW + 1)'(r_inflight);
  assign w_req = ~reset & ~r_halted & ~redirect_valid &
                 (w_occupancy < (CW + 1)'(FETCH_DEPTH) + (CW + 1)'(w_pop));

  // A response is usable only if nothing invalidated it since issue.
  assign w_resp_ok = r_inflight & ~r_kill & ~r_halted & ~redirect_valid;
  assign w_push    = w_resp_ok & (imem_rdata != END_MARKER);
  assign w_end     = w_resp_ok & (imem_rdata == END_MARKER);

  assign w_push_data = '{instr: imem_rdata, pc: r_inflight_addr};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc            <= RESET_PC;
      r_inflight      <= 1'b0;
      r_inflight_addr <= '0;
      r_kill          <= 1'b0;
      r_halted        <= 1'b0;
    end else if (redirect_valid) begin
      r_pc       <= redirect_pc & ~XLEN'(3);
      r_inflight <= 1'b0;
      r_kill     <= r_inflight;
      r_halted   <= 1'b0;
    end else begin
      r_kill     <= 1'b0;
      r_inflight <= w_req;
      if (w_req) begin
        r_pc            <= r_pc + XLEN'(4);
        r_inflight_addr <= r_pc;
      end
      if (w_end) begin
        r_halted <= 1'b1;
      end
    end
  end

  fetch_buffer #(
    .DEPTH(FETCH_DEPTH)
  ) u_fetch_buffer (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_data  (w_push_data),
    .o_count (w_count),
    .o_head  (w_head)
  );

  assign imem_req       = w_req;
  assign imem_addr      = r_pc;
  assign is_input_valid = (w_count != '0);
  assign instruction    = w_head.instr;
  assign pc_out         = w_head.pc;
  assign halted         = r_halted;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        is_input_valid;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        halted;

  // 1: word at 0xC is the end marker; 0: program continues past it
  logic        end_mode = 1'b1;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  instruction_fetch #(
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .is_input_valid (is_input_valid),
    .instruction    (instruction),
    .pc_out         (pc_out),
    .halted         (halted)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic em);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h00A0_0113;
      32'h8:   return 32'h0020_81B3;
      32'hC:   return em ? 32'h0 : 32'h0000_001F;
      default: return a | 32'h13;
    endcase
  endfunction

  // Memory model: one-cycle read latency; garbage when no request.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? mem_word(imem_addr, end_mode) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(is_input_valid), 32'd0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    // ---------------- straight-line program ending in zero word
    end_mode = 1'b1;
    do_reset();
    chk("sl_k0_req", 32'(imem_req), 32'd1);
    chk("sl_k0_addr", imem_addr, 32'h0);
    chk("sl_k0_valid", 32'(is_input_valid), 32'd0);
    tick();
    chk("sl_k1_addr", imem_addr, 32'h4);
    chk("sl_k1_valid", 32'(is_input_valid), 32'd0);
    tick();
    chk("sl_k2_valid", 32'(is_input_valid), 32'd1);
    chk("sl_k2_instr", instruction, 32'h0050_0093);
    chk("sl_k2_pc", pc_out, 32'h0);
    chk("sl_k2_addr", imem_addr, 32'h8);
    tick();
    chk("sl_k3_instr", instruction, 32'h00A0_0113);
    chk("sl_k3_pc", pc_out, 32'h4);
    chk("sl_k3_addr", imem_addr, 32'hC);
    tick();
    chk("sl_k4_instr", instruction, 32'h0020_81B3);
    chk("sl_k4_pc", pc_out, 32'h8);
    chk("sl_k4_req", 32'(imem_req), 32'd1);
    chk("sl_k4_addr", imem_addr, 32'h10);
    chk("sl_k4_halted", 32'(halted), 32'd0);
    tick();
    chk("sl_k5_valid", 32'(is_input_valid), 32'd0);
    chk("sl_k5_halted", 32'(halted), 32'd1);
    chk("sl_k5_req", 32'(imem_req), 32'd0);
    tick();
    chk("sl_k6_valid", 32'(is_input_valid), 32'd0);
    chk("sl_k6_req", 32'(imem_req), 32'd0);
    chk("sl_k6_halted", 32'(halted), 32'd1);

    // ---------------- stall with continuous program
    end_mode = 1'b0;
    do_reset();
    stall = 1'b1;
    #1;
    chk("st_k0_addr", imem_addr, 32'h0);
    tick();
    chk("st_k1_req", 32'(imem_req), 32'd1);
    chk("st_k1_addr", imem_addr, 32'h4);
    tick();
    chk("st_k2_req", 32'(imem_req), 32'd0);
    chk("st_k2_instr", instruction, 32'h0050_0093);
    for (int k = 3; k <= 6; k++) begin
      tick();
      chk($sformatf("st_k%0d_req", k), 32'(imem_req), 32'd0);
      chk($sformatf("st_k%0d_instr", k), instruction, 32'h0050_0093);
      chk($sformatf("st_k%0d_pc", k), pc_out, 32'h0);
    end
    stall = 1'b0;
    #1;
    chk("st_rel_req", 32'(imem_req), 32'd1);
    chk("st_rel_addr", imem_addr, 32'h8);
    tick();
    chk("st_k7_pc", pc_out, 32'h4);
    chk("st_k7_instr", instruction, 32'h00A0_0113);
    chk("st_k7_addr", imem_addr, 32'hC);
    tick();
    chk("st_k8_pc", pc_out, 32'h8);
    chk("st_k8_instr", instruction, 32'h0020_81B3);
    tick();
    chk("st_k9_pc", pc_out, 32'hC);
    chk("st_k9_instr", instruction, 32'h0000_001F);
    tick();
    chk("st_k10_pc", pc_out, 32'h10);
    chk("st_k10_instr", instruction, 32'h0000_0013);

    // ---------------- redirect with a response in flight
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    #1;
    chk("rd_t_req", 32'(imem_req), 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("rd_t1_valid", 32'(is_input_valid), 32'd0);
    chk("rd_t1_req", 32'(imem_req), 32'd1);
    chk("rd_t1_addr", imem_addr, 32'h100);
    tick();
    chk("rd_t2_valid", 32'(is_input_valid), 32'd0);
    tick();
    chk("rd_t3_valid", 32'(is_input_valid), 32'd1);
    chk("rd_t3_pc", pc_out, 32'h100);
    chk("rd_t3_instr", instruction, 32'h0000_0113);

    // ---------------- redirect while halted and stalled
    end_mode = 1'b1;
    do_reset();
    repeat (4) tick();
    stall = 1'b1;
    #1;
    chk("hs_k4_req", 32'(imem_req), 32'd0);
    tick();
    chk("hs_k5_halted", 32'(halted), 32'd1);
    chk("hs_k5_valid", 32'(is_input_valid), 32'd1);
    chk("hs_k5_pc", pc_out, 32'h8);
    end_mode = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    #1;
    chk("hs_t_req", 32'(imem_req), 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("hs_t1_halted", 32'(halted), 32'd0);
    chk("hs_t1_valid", 32'(is_input_valid), 32'd0);
    chk("hs_t1_addr", imem_addr, 32'h200);
    chk("hs_t1_req", 32'(imem_req), 32'd1);
    tick();
    tick();
    chk("hs_t3_valid", 32'(is_input_valid), 32'd1);
    chk("hs_t3_pc", pc_out, 32'h200);
    chk("hs_t3_instr", instruction, 32'h0000_0213);

    // ---------------- reset mid-stream with two buffered words
    end_mode = 1'b0;
    do_reset();
    stall = 1'b1;
    repeat (3) tick();
    chk("rm_k3_valid", 32'(is_input_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("rm_async_valid", 32'(is_input_valid), 32'd0);
    chk("rm_async_instr", instruction, 32'h0);
    chk("rm_async_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    stall = 1'b0;
    #1;
    chk("rm_k0_addr", imem_addr, 32'h0);
    chk("rm_k0_req", 32'(imem_req), 32'd1);
    tick();
    chk("rm_k1_valid", 32'(is_input_valid), 32'd0);
    tick();
    chk("rm_k2_pc", pc_out, 32'h0);
    chk("rm_k2_instr", instruction, 32'h0050_0093);

    // ---------------- PC wrap
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("wr_t1_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wr_t2_addr", imem_addr, 32'h0);
    chk("wr_t2_req", 32'(imem_req), 32'd1);
    tick();
    chk("wr_t3_pc", pc_out, 32'hFFFF_FFFC);
    chk("wr_t3_instr", instruction, 32'hFFFF_FFFF);
    tick();
    chk("wr_t4_pc", pc_out, 32'h0);
    chk("wr_t4_instr", instruction, 32'h0050_0093);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
